// File: rtl/rr_channel_mux.sv
`default_nettype none
// ============================================================================
//  Module   : rr_channel_mux
//  Purpose  : Registered N:1 channel multiplexer with a round-robin arbiter and
//             valid/ready handshakes on every input channel and on the output.
//             Define RR_MUX_LOCK_EN to keep a granted channel on the output
//             until the beat carrying in_last=1 has been accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_channel_mux #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 32,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_last,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel,
   output logic                      out_last,
   input  logic                      out_ready
);

   // Output register and round-robin pointer
   logic                r_out_valid;
   logic [WIDTH-1:0]    r_out_data;
   logic [SEL_W-1:0]    r_out_sel;
   logic                r_out_last;
   logic [SEL_W-1:0]    r_ptr;

   // Arbitration and datapath wires
   logic                w_load;
   logic [CHANNELS-1:0] w_req;
   logic [CHANNELS-1:0] w_mask;
   logic [CHANNELS-1:0] w_req_hi;
   logic                w_hi_any;
   logic [SEL_W-1:0]    w_hi_idx;
   logic [SEL_W-1:0]    w_lo_idx;
   logic                w_grant_any;
   logic [SEL_W-1:0]    w_grant_idx;
   logic [CHANNELS-1:0] w_grant_oh;
   logic                w_xfer;
   logic [WIDTH-1:0]    w_sel_data;
   logic                w_sel_last;
   logic [SEL_W-1:0]    w_next_ptr;
   logic                w_ptr_adv;

   // The output register can take a new beat when empty or being emptied
   assign w_load = !r_out_valid || out_ready;

`ifdef RR_MUX_LOCK_EN
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SEL_W-1:0] r_lock_ch;
   logic [SEL_W-1:0] w_lock_ch_nxt;

   // While locked only the owning channel is eligible, whether or not it is valid
   always_comb begin
      if (r_state == ST_LOCKED) begin
         w_req = in_valid & (CHANNELS'(1) << r_lock_ch);
      end else begin
         w_req = in_valid;
      end
   end

   // Lock state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_lock_ch <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_lock_ch <= w_lock_ch_nxt;
      end
   end

   // Lock next-state: a non-last beat holds the channel, a last beat releases it
   always_comb begin
      w_state_nxt   = r_state;
      w_lock_ch_nxt = r_lock_ch;
      w_ptr_adv     = 1'b0;
      if (w_xfer) begin
         if (!w_sel_last) begin
            w_state_nxt   = ST_LOCKED;
            w_lock_ch_nxt = w_grant_idx;
         end else begin
            w_state_nxt   = ST_IDLE;
            w_ptr_adv     = 1'b1;
         end
      end
   end
`else
   // Per-beat arbitration: every valid channel competes every cycle
   assign w_req     = in_valid;
   assign w_ptr_adv = w_xfer;
`endif

   // Channels at or above the pointer take priority over the wrapped-around ones
   always_comb begin
      w_mask = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_mask[c] = (c >= int'(r_ptr));
      end
   end

   assign w_req_hi    = w_req & w_mask;
   assign w_hi_any    = |w_req_hi;
   assign w_grant_any = |w_req;

   // Lowest-index requester in the upper window and in the full vector
   always_comb begin
      w_hi_idx = '0;
      w_lo_idx = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (w_req_hi[c]) begin
            w_hi_idx = SEL_W'(c);
         end
         if (w_req[c]) begin
            w_lo_idx = SEL_W'(c);
         end
      end
   end

   assign w_grant_idx = w_hi_any ? w_hi_idx : w_lo_idx;
   assign w_grant_oh  = w_grant_any ? (CHANNELS'(1) << w_grant_idx) : '0;
   assign w_xfer      = w_load && w_grant_any;
   assign w_sel_last  = |(in_last & w_grant_oh);

   // Grant is gated off during reset so no producer sees a phantom accept
   assign in_ready = (w_xfer && !reset) ? w_grant_oh : '0;

   // One-hot data mux driven by the grant vector
   always_comb begin
      w_sel_data = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (w_grant_oh[c]) begin
            w_sel_data = in_data[c*WIDTH +: WIDTH];
         end
      end
   end

   // Pointer moves just past the served channel, wrapping for any channel count
   assign w_next_ptr = (w_grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : (w_grant_idx + SEL_W'(1));

   // Round-robin pointer register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (w_ptr_adv) begin
         r_ptr <= w_next_ptr;
      end
   end

   // Output register: load on transfer, drop valid when drained, hold on stall
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_out_last  <= 1'b0;
      end else if (w_load) begin
         if (w_grant_any) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_sel   <= w_grant_idx;
            r_out_last  <= w_sel_last;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;
   assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_rr_channel_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_channel_mux
//  Purpose  : Self-checking bench for rr_channel_mux. Two instances (32 and 5
//             channels) run directed scenarios and then randomized traffic,
//             compared every cycle against a behavioural arbitration model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_channel_mux;
   localparam int W  = 32;
   localparam int N0 = 32;
   localparam int N1 = 5;
   localparam int NCH [2] = '{N0, N1};
`ifdef RR_MUX_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Producer-side stimulus per instance
   logic [63:0]  v [2];
   logic [63:0]  l [2];
   logic [W-1:0] d [2][64];
   logic         ordy [2];

   logic [N0-1:0]   iv0, il0, ir0;
   logic [N0*W-1:0] id0;
   logic            ov0, ol0;
   logic [W-1:0]    od0;
   logic [4:0]      os0;
   logic [N1-1:0]   iv1, il1, ir1;
   logic [N1*W-1:0] id1;
   logic            ov1, ol1;
   logic [W-1:0]    od1;
   logic [2:0]      os1;

   // Pack the per-channel stimulus arrays onto the DUT buses
   always_comb begin
      iv0 = v[0][N0-1:0];
      il0 = l[0][N0-1:0];
      iv1 = v[1][N1-1:0];
      il1 = l[1][N1-1:0];
      id0 = '0;
      id1 = '0;
      for (int c = 0; c < N0; c++) id0[c*W +: W] = d[0][c];
      for (int c = 0; c < N1; c++) id1[c*W +: W] = d[1][c];
   end

   rr_channel_mux #(.WIDTH(W), .CHANNELS(N0)) u_dut0 (
      .clk(clk), .reset(reset), .in_valid(iv0), .in_data(id0), .in_last(il0),
      .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_sel(os0),
      .out_last(ol0), .out_ready(ordy[0]));

   rr_channel_mux #(.WIDTH(W), .CHANNELS(N1)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(iv1), .in_data(id1), .in_last(il1),
      .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_sel(os1),
      .out_last(ol1), .out_ready(ordy[1]));

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Behavioural model: what the output register, pointer and lock should be
   int           m_ptr [2];
   bit           m_ov  [2];
   logic [W-1:0] m_od  [2];
   int           m_os  [2];
   bit           m_ol  [2];
   bit           m_lk  [2];
   int           m_lch [2];
   int           m_g   [2];
   bit           m_ld  [2];
   int           m_acc [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ptr[i] = 0; m_ov[i] = 0; m_od[i] = '0; m_os[i] = 0;
         m_ol[i] = 0;  m_lk[i] = 0; m_lch[i] = 0; m_acc[i] = -1;
      end
   endtask

   // One clock: predict grant, compare all outputs, then advance the model
   task automatic tick();
      logic [63:0] a_ir, a_od, a_os, e_ir;
      logic        a_ov, a_ol;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         m_g[i] = -1;
         if (LOCK && m_lk[i]) begin
            if (v[i][m_lch[i]]) m_g[i] = m_lch[i];
         end else begin
            for (int k = 0; k < NCH[i]; k++) begin
               int c;
               c = (m_ptr[i] + k) % NCH[i];
               if (v[i][c] && m_g[i] < 0) m_g[i] = c;
            end
         end
         m_ld[i] = !m_ov[i] || ordy[i];
         if (reset || !m_ld[i]) m_g[i] = -1;
         e_ir = (m_g[i] >= 0) ? (64'd1 << m_g[i]) : 64'd0;
         if (i == 0) begin
            a_ir = 64'(ir0); a_ov = ov0; a_od = 64'(od0); a_os = 64'(os0); a_ol = ol0;
         end else begin
            a_ir = 64'(ir1); a_ov = ov1; a_od = 64'(od1); a_os = 64'(os1); a_ol = ol1;
         end
         chk($sformatf("u%0d.in_ready", i), a_ir, e_ir);
         chk($sformatf("u%0d.out_valid", i), 64'(a_ov), 64'(m_ov[i]));
         chk($sformatf("u%0d.out_data", i), a_od, 64'(m_od[i]));
         chk($sformatf("u%0d.out_sel", i), a_os, 64'(m_os[i]));
         chk($sformatf("u%0d.out_last", i), 64'(a_ol), 64'(m_ol[i]));
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         m_acc[i] = m_g[i];
         if (reset) begin
            m_ov[i] = 0; m_od[i] = '0; m_os[i] = 0; m_ol[i] = 0;
            m_ptr[i] = 0; m_lk[i] = 0;
         end else if (m_ld[i]) begin
            if (m_g[i] >= 0) begin
               m_ov[i] = 1;
               m_od[i] = d[i][m_g[i]];
               m_os[i] = m_g[i];
               m_ol[i] = l[i][m_g[i]];
               if (LOCK && !l[i][m_g[i]]) begin
                  m_lk[i]  = 1;
                  m_lch[i] = m_g[i];
               end else begin
                  m_lk[i]  = 0;
                  m_ptr[i] = (m_g[i] + 1) % NCH[i];
               end
            end else begin
               m_ov[i] = 0;
            end
         end
      end
      #1;
   endtask

   // Random producers: retire accepted beats, occasionally offer new ones
   task automatic produce(input int i, input int pct);
      for (int c = 0; c < NCH[i]; c++) begin
         if (m_acc[i] == c) v[i][c] = 1'b0;
         if (!v[i][c] && ($urandom_range(99) < pct)) begin
            v[i][c] = 1'b1;
            d[i][c] = $urandom;
            l[i][c] = ($urandom_range(3) == 0);
         end
      end
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 2; i++) begin
         v[i] = '0;
         l[i] = '0;
         for (int c = 0; c < 64; c++) d[i][c] = '0;
      end
   endtask

   initial begin
      int exp_wrap [4];
      int exp_lock [5];
      int cnt;
      exp_wrap = '{0, 4, 0, 4};
      if (LOCK) exp_lock = '{1, 1, 1, 3, 3};
      else      exp_lock = '{1, 3, 1, 3, 1};

      // Reset state
      reset = 1'b1;
      ordy[0] = 1'b1;
      ordy[1] = 1'b1;
      clear_inputs();
      @(posedge clk); #1;
      model_reset();
      tick();
      tick();

      // Single request on channel 5
      reset = 1'b0;
      v[0][5] = 1'b1; d[0][5] = 32'hDEADBEEF; l[0][5] = 1'b1;
      #1;
      chk("single.in_ready", 64'(ir0), 64'h20);
      tick();
      v[0][5] = 1'b0;
      chk("single.valid", 64'(ov0), 64'd1);
      chk("single.data", 64'(od0), 64'hDEADBEEF);
      chk("single.sel", 64'(os0), 64'd5);

      // Fairness with every channel valid
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int c = 0; c < N0; c++) begin
         v[0][c] = 1'b1; l[0][c] = 1'b1; d[0][c] = $urandom;
      end
      for (int k = 0; k < 64; k++) begin
         tick();
         chk("fair.sel", 64'(os0), 64'(k % N0));
         chk("fair.valid", 64'(ov0), 64'd1);
         if (m_acc[0] >= 0) d[0][m_acc[0]] = $urandom;
      end
      v[0] = '0;

      // Wrap on the 5-channel instance: only channels 0 and 4 request
      v[1][0] = 1'b1; v[1][4] = 1'b1; l[1][0] = 1'b1; l[1][4] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("wrap.sel", 64'(os1), 64'(exp_wrap[k]));
         if (m_acc[1] >= 0) d[1][m_acc[1]] = $urandom;
      end

      // Backpressure: outputs freeze, no grant, then channel 2 resumes
      v[1] = '0;
      v[1][2] = 1'b1; l[1][2] = 1'b0; d[1][2] = 32'h0BAD_F00D;
      ordy[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp.in_ready", 64'(ir1), 64'd0);
         chk("bp.sel", 64'(os1), 64'd4);
      end
      ordy[1] = 1'b1;
      tick();
      v[1][2] = 1'b0;
      chk("bp.resume_sel", 64'(os1), 64'd2);
      chk("bp.resume_data", 64'(od1), 64'h0BAD_F00D);
      tick();

      // Packet lock: channel 1 sends last=0,0,1 while channel 3 keeps requesting
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_inputs();
      v[0][1] = 1'b1; l[0][1] = 1'b0; d[0][1] = $urandom;
      v[0][3] = 1'b1; l[0][3] = 1'b1; d[0][3] = $urandom;
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("lock.sel", 64'(os0), 64'(exp_lock[k]));
         if (m_acc[0] == 1) begin
            cnt++;
            d[0][1] = $urandom;
            l[0][1] = (cnt == 2);
            if (cnt == 3) v[0][1] = 1'b0;
         end else if (m_acc[0] == 3) begin
            d[0][3] = $urandom;
         end
      end

      // Reset in the middle of a packet on channel 1
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_inputs();
      v[0][1] = 1'b1; l[0][1] = 1'b0; d[0][1] = 32'h1111_0001;
      v[0][3] = 1'b1; l[0][3] = 1'b1; d[0][3] = 32'h3333_0003;
      tick();
      chk("midrst.sel_before", 64'(os0), 64'd1);
      reset = 1'b1;
      tick();
      chk("midrst.valid", 64'(ov0), 64'd0);
      reset = 1'b0;
      v[0][1] = 1'b0;
      tick();
      chk("midrst.sel_after", 64'(os0), 64'd3);
      chk("midrst.data_after", 64'(od0), 64'h3333_0003);
      v[0][3] = 1'b0;
      tick();

      // Randomized traffic with random backpressure and occasional reset
      clear_inputs();
      for (int k = 0; k < 3000; k++) begin
         ordy[0] = ($urandom_range(3) != 0);
         ordy[1] = ($urandom_range(4) != 0);
         reset   = ($urandom_range(299) == 0);
         tick();
         produce(0, 20);
         produce(1, 45);
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
